jtdsp16_prog_rom: RTL and testbench

- Program-memory responder that serves the instruction fetch address issued by the XAAU and returns the 16-bit instruction word.
- Addresses below 2^AW with exm low come from an internal ROM, which is loaded through a download port.
- All other addresses are fetched over an external req/ok memory bus, with a one-word tag buffer so that repeated fetches of the same address do not refetch.
- Drives rom_wait so the core can freeze its clock enable while an external fetch is outstanding.

---
 rtl/jtdsp16_prog_rom.sv | 119 +++++++++++
 tb/tb_jtdsp16_prog_rom.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/jtdsp16_prog_rom.sv
// rtl/jtdsp16_prog_rom.sv - DSP16 program memory: internal download ROM plus tagged external fetch
module jtdsp16_prog_rom #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [15:0]   rom_req,
  input  logic          exm,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  output logic [15:0]   ext_addr,
  output logic          ext_cs,
  input  logic [15:0]   ext_data,
  input  logic          ext_ok,
  output logic [15:0]   rom_dout,
  output logic          rom_wait
);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  logic [15:0] mem [0:(2**AW)-1];

  state_t      state_q, state_d;
  logic [15:0] rom_dout_q, rom_dout_d;
  logic [15:0] ext_addr_q, ext_addr_d;
  logic        ext_cs_q, ext_cs_d;
  logic [15:0] tag_q, tag_d;
  logic [15:0] buf_q, buf_d;
  logic        valid_q, valid_d;

  logic        is_int, is_hit, is_miss;
  logic [15:0] rd_word;

  // Classify the presented address; the ROM read is combinational so a same-edge download sees the old word
  always_comb begin
    is_int  = ~exm & ((rom_req >> AW) == 16'd0);
    is_hit  = ~is_int & valid_q & (tag_q == rom_req);
    is_miss = ~is_int & ~is_hit;
    rd_word = mem[rom_req[AW-1:0]];
  end

  // Next-state and next-output logic for the fetch controller
  always_comb begin
    state_d    = state_q;
    rom_dout_d = rom_dout_q;
    ext_addr_d = ext_addr_q;
    ext_cs_d   = ext_cs_q;
    tag_d      = tag_q;
    buf_d      = buf_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: begin
        if (cen) begin
          if (is_int) begin
            rom_dout_d = rd_word;
          end else if (is_hit) begin
            rom_dout_d = buf_q;
          end else begin
            ext_addr_d = rom_req;
            ext_cs_d   = 1'b1;
            state_d    = FETCH;
          end
        end
      end
      FETCH: begin
        // cen and rom_req are ignored until the external word arrives
        if (ext_ok) begin
          rom_dout_d = ext_data;
          buf_d      = ext_data;
          tag_d      = ext_addr_q;
          valid_d    = 1'b1;
          ext_cs_d   = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rom_dout_q <= 16'd0;
      ext_addr_q <= 16'd0;
      ext_cs_q   <= 1'b0;
      tag_q      <= 16'd0;
      buf_q      <= 16'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_dout_q <= rom_dout_d;
      ext_addr_q <= ext_addr_d;
      ext_cs_q   <= ext_cs_d;
      tag_q      <= tag_d;
      buf_q      <= buf_d;
      valid_q    <= valid_d;
    end
  end

  // Download port writes the ROM on any clock, regardless of cen or fetch state
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Stall the core while a fetch is outstanding, and in the cycle a miss is presented
  always_comb begin
    rom_wait = ~rst & ((state_q == FETCH) | (cen & is_miss & (state_q == IDLE)));
  end

  assign rom_dout = rom_dout_q;
  assign ext_addr = ext_addr_q;
  assign ext_cs   = ext_cs_q;

endmodule

// File: tb/tb_jtdsp16_prog_rom.sv
// tb/tb_jtdsp16_prog_rom.sv - self-checking bench for jtdsp16_prog_rom
module tb_jtdsp16_prog_rom;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst, cen, exm, prog_we, ext_ok;
  logic [15:0]   rom_req, prog_data, ext_data;
  logic [AW-1:0] prog_addr;
  logic [15:0]   ext_addr, rom_dout;
  logic          ext_cs, rom_wait;

  jtdsp16_prog_rom #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .rom_req(rom_req), .exm(exm),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .ext_addr(ext_addr), .ext_cs(ext_cs), .ext_data(ext_data), .ext_ok(ext_ok),
    .rom_dout(rom_dout), .rom_wait(rom_wait)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: memory contents, one-entry buffer, last delivered word
  logic [15:0] m_mem [int];
  logic        m_valid;
  logic [15:0] m_tag, m_buf, m_dout;
  logic [15:0] dl_addrs [8];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic download(input logic [15:0] a, input logic [15:0] d);
    prog_addr = a[AW-1:0];
    prog_data = d;
    prog_we   = 1'b1;
    step();
    prog_we   = 1'b0;
    m_mem[int'(a)] = d;
  endtask

  // One fetch presented for a single cen cycle; a miss is served after 'delay' cycles of ext_cs
  task automatic fetch(input logic [15:0] a, input logic x, input int delay);
    logic [15:0] d;
    rom_req = a;
    exm     = x;
    cen     = 1'b1;
    #1;
    if (!x && int'(a) < (1 << AW)) begin
      chk("int_wait", {15'd0, rom_wait}, 16'd0);
      step();
      cen = 1'b0;
      m_dout = m_mem[int'(a)];
      chk("int_dout", rom_dout, m_dout);
      chk("int_cs", {15'd0, ext_cs}, 16'd0);
    end else if (m_valid && m_tag == a) begin
      chk("hit_wait", {15'd0, rom_wait}, 16'd0);
      step();
      cen = 1'b0;
      m_dout = m_buf;
      chk("hit_dout", rom_dout, m_dout);
      chk("hit_cs", {15'd0, ext_cs}, 16'd0);
    end else begin
      chk("miss_wait_req", {15'd0, rom_wait}, 16'd1);
      step();
      cen = 1'b0;
      chk("miss_cs", {15'd0, ext_cs}, 16'd1);
      chk("miss_addr", ext_addr, a);
      chk("miss_wait", {15'd0, rom_wait}, 16'd1);
      for (int k = 1; k < delay; k++) begin
        cen     = 1'($urandom);
        rom_req = 16'($urandom);
        ext_ok  = 1'b0;
        step();
        chk("miss_cs_hold", {15'd0, ext_cs}, 16'd1);
        chk("miss_addr_hold", ext_addr, a);
        chk("miss_wait_hold", {15'd0, rom_wait}, 16'd1);
      end
      cen      = 1'b0;
      d        = 16'($urandom);
      ext_data = d;
      ext_ok   = 1'b1;
      step();
      ext_ok   = 1'b0;
      ext_data = 16'($urandom);
      m_valid = 1'b1;
      m_tag   = a;
      m_buf   = d;
      m_dout  = d;
      chk("fill_dout", rom_dout, d);
      chk("fill_cs", {15'd0, ext_cs}, 16'd0);
      chk("fill_wait", {15'd0, rom_wait}, 16'd0);
    end
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0; exm = 1'b0; prog_we = 1'b0; ext_ok = 1'b0;
    rom_req = 16'd0; prog_data = 16'd0; prog_addr = '0; ext_data = 16'd0;
    m_valid = 1'b0; m_tag = 16'd0; m_buf = 16'd0; m_dout = 16'd0;
    step();
    chk("rst_dout", rom_dout, 16'd0);
    chk("rst_cs", {15'd0, ext_cs}, 16'd0);
    chk("rst_addr", ext_addr, 16'd0);
    chk("rst_wait", {15'd0, rom_wait}, 16'd0);
    rst = 1'b0;
    step();

    // Internal fetch of downloaded word
    download(16'h0005, 16'hA5A5);
    fetch(16'h0005, 1'b0, 1);

    // External miss with 3-cycle latency, then a hit
    fetch(16'h1234, 1'b0, 3);
    fetch(16'h1234, 1'b0, 1);

    // exm forces internal range external
    fetch(16'h0005, 1'b1, 2);
    fetch(16'h0005, 1'b1, 1);
    fetch(16'h1234, 1'b0, 2);

    // cen low holds the output
    rom_req = 16'h0005; exm = 1'b0; cen = 1'b0;
    step();
    chk("hold_dout", rom_dout, m_dout);
    chk("hold_cs", {15'd0, ext_cs}, 16'd0);

    // Reset during FETCH drops ext_cs and discards a late ext_ok
    rom_req = 16'h4444; exm = 1'b0; cen = 1'b1;
    step();
    cen = 1'b0;
    chk("rf_cs_before", {15'd0, ext_cs}, 16'd1);
    rst = 1'b1;
    #1;
    chk("rf_cs_async", {15'd0, ext_cs}, 16'd0);
    chk("rf_dout_async", rom_dout, 16'd0);
    chk("rf_wait_async", {15'd0, rom_wait}, 16'd0);
    step();
    rst = 1'b0;
    ext_ok = 1'b1; ext_data = 16'h5A5A;
    step();
    ext_ok = 1'b0;
    chk("rf_cs_late_ok", {15'd0, ext_cs}, 16'd0);
    chk("rf_dout_late_ok", rom_dout, 16'd0);
    m_valid = 1'b0; m_dout = 16'd0;
    fetch(16'h1234, 1'b0, 2);

    // Read-before-write on a simultaneous download
    prog_addr = 12'h005; prog_data = 16'h1111; prog_we = 1'b1;
    rom_req = 16'h0005; exm = 1'b0; cen = 1'b1;
    #1;
    chk("rbw_wait", {15'd0, rom_wait}, 16'd0);
    step();
    prog_we = 1'b0; cen = 1'b0;
    chk("rbw_old", rom_dout, 16'hA5A5);
    m_mem[5] = 16'h1111;
    fetch(16'h0005, 1'b0, 1);

    // Downloads do not disturb the buffer
    download(16'h0ABC, 16'h7777);
    fetch(16'h1234, 1'b0, 1);

    // Randomized mix against the model, including the 0xFFFF and 0x0FFF boundaries
    dl_addrs[0] = 16'h0000;
    dl_addrs[1] = 16'h0FFF;
    for (int i = 2; i < 8; i++) dl_addrs[i] = 16'($urandom_range(0, (1 << AW) - 1));
    for (int i = 0; i < 8; i++) download(dl_addrs[i], 16'($urandom));
    for (int it = 0; it < 30; it++) begin
      logic [15:0] a;
      logic        x;
      int          r;
      r = $urandom_range(0, 4);
      x = 1'b0;
      case (r)
        0: a = dl_addrs[$urandom_range(0, 7)];
        1: begin a = dl_addrs[$urandom_range(0, 7)]; x = 1'b1; end
        2: a = 16'($urandom_range(1 << AW, 16'hFFFF));
        3: begin a = m_tag; x = 1'($urandom); if (!m_valid) a = 16'hFFFF; end
        default: a = 16'hFFFF;
      endcase
      if (x == 1'b0 && int'(a) < (1 << AW) && !m_mem.exists(int'(a))) a = dl_addrs[0];
      fetch(a, x, $urandom_range(1, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
